// File: rtl/serial_framer_pkg.sv
// Shared types and helpers for the serial framer: FSM state encoding and frame length.
package serial_framer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Total clk cycles of one frame: start + payload + optional parity + stop, each DIV long.
    function automatic int frame_len(input int n, input int div, input int parity_en);
        return (n + 2 + parity_en) * div;
    endfunction

endpackage

// File: rtl/serial_framer_if.sv
// Parallel word handshake into the serial framer.
// A word transfers on a rising clk edge where din_valid and din_ready are both 1; din is only sampled then.
interface serial_framer_if #(
    parameter int N = 8
);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/baud_divider.sv
// Bit-period timer: tick is high during the last of DIV cycles of each serial bit.
// tick_next is the value tick takes after the coming edge, so callers can register pulses that align with it.
module baud_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick,
    output logic tick_next
);
    localparam int CW = $clog2(DIV) + 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d     = '0;
        tick_next = 1'b0;
        if (en) begin
            if (restart || tick) begin
                cnt_d     = '0;
                tick_next = (DIV == 1);
            end else begin
                cnt_d     = cnt + CW'(1);
                tick_next = (cnt_d == CW'(DIV - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tick <= tick_next;
        end
    end
endmodule

// File: rtl/serial_framer.sv
// Serialises N-bit words as start(0), payload LSB first, optional even parity, stop(1),
// each bit held DIV cycles; a word accepted in the last stop cycle starts the next frame with no gap.
module serial_framer
    import serial_framer_pkg::*;
#(
    parameter int N         = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic           clk,
    input  logic           reset,
    serial_framer_if.slave bus,
    output logic           data,
    output logic           busy,
    output logic           frame_done,
    output state_t         fsm_state
);
    localparam int IW = $clog2(N) + 1;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] bit_idx;
    logic [N-1:0]  word;
    logic [N-1:0]  shifted;
    logic          tick;
    logic          tick_next;
    logic          accept;
    logic          last_bit;

    assign bus.din_ready = reset && ((state == IDLE) || ((state == STOP) && tick));
    assign accept        = bus.din_valid && bus.din_ready;
    assign last_bit      = (bit_idx == IW'(N - 1));
    assign shifted       = word >> (bit_idx + IW'(1));
    assign fsm_state     = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = START;
            START:   if (tick) next_state = DATA;
            DATA:    if (tick && last_bit) next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (tick) next_state = STOP;
            STOP:    if (tick) next_state = accept ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    baud_divider #(.DIV(DIV)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .en        (next_state != IDLE),
        .restart   (accept),
        .tick      (tick),
        .tick_next (tick_next)
    );

    // data is loaded on the edge that ends the previous bit so it lines up with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            data       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_idx    <= '0;
            word       <= '0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != IDLE);
            frame_done <= (next_state == STOP) && tick_next;
            if (accept) begin
                word    <= bus.din;
                data    <= 1'b0;
                bit_idx <= '0;
            end else if (tick) begin
                case (state)
                    START: begin
                        data    <= word[0];
                        bit_idx <= '0;
                    end
                    DATA: begin
                        if (last_bit) begin
                            data <= (PARITY_EN != 0) ? ^word : 1'b1;
                        end else begin
                            data    <= shifted[0];
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                    default: data <= 1'b1;
                endcase
            end
        end
    end
endmodule
